// File: rtl/iir1_pkg.sv
// Shared types and defaults for the time-multiplexed first-order IIR scheduler.
// Optional build macro IIR1_SAT_EN (used by iir1_mult_sched) selects saturating output.
package iir1_pkg;

  // Default datapath width and coefficient reset values.
  localparam int DEF_DW      = 16;
  localparam int DEF_B4_INIT = 19071;
  localparam int DEF_B6_INIT = 16381;

  // Scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Tap index carried alongside each in-flight multiply.
  localparam logic [1:0] TAP_X0 = 2'd0; // x[n]   * b4
  localparam logic [1:0] TAP_X1 = 2'd1; // x[n-1] * b4
  localparam logic [1:0] TAP_Y1 = 2'd2; // y[n-1] * b6

  // One tag-pipe entry.
  typedef struct packed {
    logic       valid;
    logic [1:0] tap;
  } tag_t;

endpackage

// File: rtl/iir1_tag_pipe.sv
// Tag pipe that mirrors the external multiplier latency: an entry pushed with an
// operand pair emerges exactly when the matching product is on mul_q.
module iir1_tag_pipe
  import iir1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];

  // Shift tags one stage per cycle; reset invalidates every entry so that
  // products still in the multiplier at reset time are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/iir1_mult_sched.sv
// First-order IIR section y[n] = b4*x[n] + b4*x[n-1] + b6*y[n-1] computed with
// one shared external pipelined multiplier (three issues per sample).
// Handshake: a sample transfers on a rising clk edge where in_valid && in_ready;
// in_ready is high only in IDLE (and not during reset), so the source holds
// in_valid/x_in until that edge. out_valid is a one-cycle pulse with y_out.
// Build macro IIR1_SAT_EN: accumulate in DW+2 signed bits and clamp the result;
// without it the sum wraps modulo 2^DW.
module iir1_mult_sched
  import iir1_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int MULT_LAT = 2,
  parameter int B4_INIT  = DEF_B4_INIT,
  parameter int B6_INIT  = DEF_B6_INIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  input  logic          cfg_we,
  input  logic          cfg_sel,
  input  logic [DW-1:0] cfg_data,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  input  logic [DW-1:0] mul_q,
  output logic [DW-1:0] y_out,
  output logic          out_valid,
  output logic          busy
);

`ifdef IIR1_SAT_EN
  localparam int AW = DW + 2;
  localparam logic [AW-1:0] SAT_MAX = AW'((1 << (DW - 1)) - 1);
  localparam logic [AW-1:0] SAT_MIN = ~SAT_MAX;
`else
  localparam int AW = DW;
`endif

  state_t        state_q, state_d;
  logic [1:0]    tap_q, tap_d;
  logic [DW-1:0] mul_a_q, mul_a_d;
  logic [DW-1:0] mul_b_q, mul_b_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] prod_ext;
  logic [DW-1:0] y_fin;
  logic [DW-1:0] b4_q, b6_q;
  logic [DW-1:0] b4w_q, b6w_q;
  logic [DW-1:0] x_cur_q, x_prev_q, y_prev_q, y_out_q;
  logic          accept;
  logic          finish;
  tag_t          tag_in, tag_out;

  assign in_ready  = (state_q == ST_IDLE) && reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign y_out     = y_out_q;

  // Product extension into the accumulator width, and the final result.
`ifdef IIR1_SAT_EN
  assign prod_ext = {{2{mul_q[DW-1]}}, mul_q};

  // Clamp the wide signed sum into the DW-bit signed range.
  always_comb begin
    y_fin = acc_d[DW-1:0];
    if ($signed(acc_d) > $signed(SAT_MAX)) begin
      y_fin = SAT_MAX[DW-1:0];
    end else if ($signed(acc_d) < $signed(SAT_MIN)) begin
      y_fin = SAT_MIN[DW-1:0];
    end
  end
`else
  assign prod_ext = mul_q;
  assign y_fin    = acc_d;
`endif

  // Multiplier latency tracker.
  iir1_tag_pipe #(
    .DEPTH (MULT_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Next-state, operand selection, tag push and accumulation.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    mul_a_d = '0;
    mul_b_d = '0;
    acc_d   = acc_q;
    tag_in  = '0;
    if (tag_out.valid) begin
      acc_d = acc_q + prod_ext;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          tap_d   = TAP_X0;
          mul_a_d = x_in;
          mul_b_d = b4_q;
          acc_d   = '0;
        end
      end
      ST_ISSUE: begin
        // The operand registers currently present tap_q; line up the next one.
        tag_in.valid = 1'b1;
        tag_in.tap   = tap_q;
        case (tap_q)
          TAP_X0: begin
            tap_d   = TAP_X1;
            mul_a_d = x_prev_q;
            mul_b_d = b4w_q;
          end
          TAP_X1: begin
            tap_d   = TAP_Y1;
            mul_a_d = y_prev_q;
            mul_b_d = b6w_q;
          end
          default: begin
            state_d = ST_WAIT;
          end
        endcase
      end
      ST_WAIT: begin
        if (tag_out.valid && (tag_out.tap == TAP_Y1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign finish = (state_q == ST_WAIT) && (state_d == ST_DONE);

  // FSM state, operand registers and accumulator.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tap_q   <= TAP_X0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      acc_q   <= acc_d;
    end
  end

  // Programmable coefficients; writable in any state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      b4_q <= DW'(B4_INIT);
      b6_q <= DW'(B6_INIT);
    end else if (cfg_we) begin
      if (cfg_sel) begin
        b6_q <= cfg_data;
      end else begin
        b4_q <= cfg_data;
      end
    end
  end

  // Per-sample snapshot, filter history and registered output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_cur_q  <= '0;
      b4w_q    <= DW'(B4_INIT);
      b6w_q    <= DW'(B6_INIT);
      x_prev_q <= '0;
      y_prev_q <= '0;
      y_out_q  <= '0;
    end else begin
      if (accept) begin
        // Snapshot sees the pre-write coefficient if cfg_we fires this cycle.
        x_cur_q <= x_in;
        b4w_q   <= b4_q;
        b6w_q   <= b6_q;
      end
      if (finish) begin
        y_out_q <= y_fin;
      end
      if (state_q == ST_DONE) begin
        x_prev_q <= x_cur_q;
        y_prev_q <= y_out_q;
      end
    end
  end

endmodule

// File: tb/tb_iir1_mult_sched.sv
// Directed bench for iir1_mult_sched with a behavioural pipelined multiplier.
module tb_iir1_mult_sched;

  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x_in = '0;
  logic          cfg_we = 1'b0;
  logic          cfg_sel = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic [DW-1:0] mul_a, mul_b, mul_q;
  logic [DW-1:0] y_out;
  logic          out_valid;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  // Clock.
  always #5 clk = ~clk;

  iir1_mult_sched #(
    .DW       (DW),
    .MULT_LAT (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_q     (mul_q),
    .y_out     (y_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  // Behavioural multiplier: low DW bits of a*b, LAT cycles later.
  logic [DW-1:0] mp [LAT] = '{default: '0};
  always @(posedge clk) begin
    mp[0] <= DW'(mul_a * mul_b);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_q = mp[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All driver tasks start and end just after a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cfg_write(input logic sel, input logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Presents x until accepted; returns at the first falling edge after the accept.
  task automatic send(input logic [DW-1:0] x);
    int n = 0;
    in_valid = 1'b1; x_in = x;
    while (!in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; lat is the number of falling edges since the accept.
  task automatic wait_out(input string tag, input logic [DW-1:0] exp_y, input int lat0);
    int lat = lat0;
    while (!out_valid && lat < 30) begin
      @(negedge clk); lat++;
    end
    chk({tag, "_lat"}, lat, 4 + LAT);
    chk({tag, "_y"}, y_out, exp_y);
    @(negedge clk);
    chk({tag, "_pulse"}, out_valid, 1'b0);
  endtask

  logic [DW-1:0] xs [3] = '{16'd1, 16'd2, 16'd3};
  logic [DW-1:0] ys [3] = '{16'd2, 16'd12, 16'd46};
  logic [DW-1:0] sat_exp;
  int cyc, n_acc, n_out, prev_acc, low_cnt, ov_cnt;
  logic pend;

  initial begin
    // Reset state.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y_out", y_out, 16'd0);
    chk("rst_mul_a", mul_a, 16'd0);
    chk("rst_mul_b", mul_b, 16'd0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);

    // Default coefficients: b4 via x=1, b6 via the following x=0.
    send(16'd1);
    chk("busy_issue", busy, 1'b1);
    chk("ready_issue", in_ready, 1'b0);
    wait_out("def_b4", 16'd19071, 1);
    send(16'd0);
    wait_out("def_b6", 16'd11010, 1);

    // Programmed coefficients, history path.
    do_reset();
    cfg_write(1'b0, 16'd2);
    cfg_write(1'b1, 16'd3);
    send(16'd5);
    wait_out("p_x5", 16'd10, 1);
    send(16'd0);
    wait_out("p_x0", 16'd40, 1);

    // Back-to-back with in_valid held high.
    do_reset();
    cfg_write(1'b0, 16'd2);
    cfg_write(1'b1, 16'd3);
    cyc = 0; n_acc = 0; n_out = 0; prev_acc = 0; low_cnt = 0; pend = 1'b0;
    in_valid = 1'b1; x_in = xs[0];
    while (cyc < 34) begin
      if (pend) begin
        if (n_acc < 3) x_in = xs[n_acc];
        else in_valid = 1'b0;
        pend = 1'b0;
      end
      if (out_valid) begin
        if (n_out < 3) chk("b2b_y", y_out, ys[n_out]);
        n_out++;
      end
      if (in_valid && in_ready) begin
        if (n_acc > 0) begin
          chk("b2b_spacing", cyc - prev_acc, 5 + LAT);
          chk("b2b_ready_low", low_cnt, 4 + LAT);
        end
        prev_acc = cyc; low_cnt = 0; n_acc++; pend = 1'b1;
      end else if (!in_ready) begin
        low_cnt++;
      end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_outputs", n_out, 3);

    // Overflow: wrap or clamp.
    do_reset();
    cfg_write(1'b0, 16'd1);
    cfg_write(1'b1, 16'd1);
    send(16'h7000);
    wait_out("ovf_first", 16'h7000, 1);
`ifdef IIR1_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h5000;
`endif
    send(16'h7000);
    wait_out("ovf_second", sat_exp, 1);

    // Coefficient write while a sample is in WAIT.
    do_reset();
    cfg_write(1'b0, 16'd2);
    cfg_write(1'b1, 16'd3);
    send(16'd1);
    repeat (3) @(negedge clk);
    cfg_write(1'b0, 16'd7);
    wait_out("cfgw_cur", 16'd2, 5);
    send(16'd0);
    wait_out("cfgw_next", 16'd13, 1);

    // Reset pulsed while WAITing: sample dropped, history cleared.
    send(16'd3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) ov_cnt++;
      @(negedge clk);
    end
    chk("midrst_no_out", ov_cnt, 0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_y_out", y_out, 16'd0);
    cfg_write(1'b0, 16'd1);
    cfg_write(1'b1, 16'd1);
    send(16'd4);
    wait_out("midrst_x4", 16'd4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iir1_mult_sched.md
Name: iir1_mult_sched

Overview:
Time-multiplexed scheduler for the first-order IIR section, y[n] = b4·x[n] + b4·x[n-1] + b6·y[n-1].
- Shares one external pipelined de_mult instance across the three products of each sample, instead of using three multipliers.
- Accepts samples via valid/ready, issues three multiplies, accumulates the returned products and emits one output per sample.
- Holds the x[n-1]/y[n-1] history and the programmable coefficient registers.

Parameters:
DW, 16, sample/coefficient/product width
MULT_LAT, 2, cycles from mul_a/mul_b issue to matching mul_q (≥1)
B4_INIT, 19071, reset value of b4
B6_INIT, 16381, reset value of b6

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  x_in valid
in_ready  out  1  scheduler can accept a sample
x_in  in  DW  input sample (two's complement)
cfg_we  in  1  coefficient write strobe
cfg_sel  in  1  0=b4, 1=b6
cfg_data  in  DW  coefficient value
mul_a  out  DW  multiplier operand A
mul_b  out  DW  multiplier operand B
mul_q  in  DW  multiplier result, MULT_LAT after issue
y_out  out  DW  filter output
out_valid  out  1  one-cycle pulse, y_out valid
busy  out  1  high in any state except IDLE

Behaviour:
Reset (reset=0 at posedge), also when asserted mid-operation:
- state=IDLE; in_ready=0 during reset, 1 afterwards.
- out_valid=0, y_out=0, mul_a=mul_b=0, accumulator=0.
- x_prev=y_prev=0; b4=B4_INIT, b6=B6_INIT.
- All tag-pipe entries invalid; products returning after reset are discarded.

FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at cycle T: latch x_cur=x_in, snapshot b4/b6 into working copies, clear accumulator, go to ISSUE with tap=0.
- ISSUE (cycles T+1..T+3), one issue per cycle; mul_a/mul_b are registered outputs driven in these cycles:
  - tap0: a=x_cur, b=b4
  - tap1: a=x_prev, b=b4
  - tap2: a=y_prev, b=b6
  - Each issue pushes a valid tag into a MULT_LAT-deep tag pipe. After tap2, go to WAIT.
- WAIT: each cycle the tag pipe output is valid, acc <= acc + mul_q. Accumulation is DW-bit modulo 2^DW. When the tap2 tag retires (cycle T+3+MULT_LAT), go to DONE.
- DONE (cycle T+4+MULT_LAT): y_out=acc (registered), out_valid=1 for exactly one cycle, x_prev<=x_cur, y_prev<=acc, go to IDLE. in_ready rises the next cycle.
- Sample period: 5+MULT_LAT cycles. in_ready=0 in ISSUE/WAIT/DONE; in_valid is ignored there and the source must hold it.

mul_a/mul_b outside ISSUE: hold 0.

y_out: holds its last value between out_valid pulses.

Coefficient writes:
- cfg_we updates b4/b6 at the next edge, in any state.
- The in-flight sample uses its snapshot; a new value applies from the next accept.
- A cfg write in the same cycle as an accept: the accept snapshots the old value.

Optional Feature:
IIR1_SAT_EN
- Defined: accumulate signed in DW+2 bits; at DONE clamp to [-2^(DW-1), 2^(DW-1)-1] before driving y_out and y_prev.
- Undefined: plain DW-bit wrap-around, bit-identical to the three-multiplier section.

Decomposition:
- Package iir1_pkg: state enum; tap index constants TAP_X0/TAP_X1/TAP_Y1; DW; B4_INIT/B6_INIT defaults.
- One sub-module, iir1_tag_pipe: MULT_LAT-deep shift register of {valid, tap[1:0]}, cleared by reset. Its output drives accumulate-enable and last-tap detection.

Test Plan:
Bench uses a behavioural multiplier model: mul_q = low DW bits of a·b, delayed MULT_LAT cycles.
- Reset then idle: all outputs 0 during reset; in_ready=1 afterwards; b4=19071, b6=16381 readable via behaviour (x=1 → y_out=19071).
- Set b4=2, b6=3. Send x=5 then x=0 → y_out=10, then 40. out_valid exactly 6 cycles after each accept (MULT_LAT=2).
- Back-to-back in_valid held high: accept spacing 7 cycles; in_ready low exactly 6 cycles per sample; no sample lost or duplicated.
- b4=b6=1, x=0x7000 twice → second y_out=0x5000 without IIR1_SAT_EN, 0x7FFF with it.
- cfg write b4=7 during WAIT of sample x=1 (b4=2) → current y_out=2; next sample x=0 → y_out uses new b4 for tap1 only on later samples (tap1 = 7·1 = 7, plus b6·2).
- Reset pulsed in WAIT → no out_valid; next sample x=4 with b4=1, b6=1 → y_out=4 (history cleared).
